// File: rtl/gen_skid_pipe_if.sv
// Valid/ready handshake bundle for the elastic skid stage.
// slave faces the stage, master faces the producer/consumer pair.
interface gen_skid_pipe_if #(
   parameter int unsigned DW = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/gen_skid_pipe.sv
// Two-entry elastic pipeline stage: main register plus skid register.
// in_ready is registered so downstream stalls never ripple combinationally.
module gen_skid_pipe #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [DW-1:0] def_val,
   gen_skid_pipe_if.slave bus,
   output logic [1:0]    count
);

   logic          main_v_q, main_v_d;
   logic          skid_v_q, skid_v_d;
   logic [DW-1:0] main_q,   main_d;
   logic [DW-1:0] skid_q,   skid_d;

   logic in_fire;
   logic out_fire;
   logic main_ld;

   assign bus.in_ready  = ~skid_v_q;
   assign bus.out_valid = main_v_q;
   assign bus.out_data  = main_q;
   assign count         = {1'b0, main_v_q} + {1'b0, skid_v_q};

   assign in_fire  = bus.in_valid & ~skid_v_q;
   assign out_fire = main_v_q & bus.out_ready;
   assign main_ld  = ~main_v_q | out_fire;

   always_comb begin
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      main_d   = main_q;
      skid_d   = skid_q;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
         main_d   = def_val;
         skid_d   = def_val;
      end else begin
         if (main_ld) begin
            if (skid_v_q) begin
               main_d   = skid_q;
               main_v_d = 1'b1;
               skid_v_d = 1'b0;
            end else if (in_fire) begin
               main_d   = bus.in_data;
               main_v_d = 1'b1;
            end else begin
               main_v_d = 1'b0;
            end
         end
         // Main is busy and not draining: park the new word in the skid slot.
         if (in_fire && main_v_q && !out_fire) begin
            skid_d   = bus.in_data;
            skid_v_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         main_q   <= def_val;
         skid_q   <= def_val;
      end else begin
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         main_q   <= main_d;
         skid_q   <= skid_d;
      end
   end

endmodule

// File: tb/tb_gen_skid_pipe.sv
// Vector table plus FIFO scoreboard for the elastic skid stage.
// Expected data queue is filled on accepted input, drained on output.
module tb_gen_skid_pipe;

   localparam int unsigned DW = 32;
   localparam int NV = 22;

   typedef struct {
      logic          fl;
      logic          iv;
      logic [DW-1:0] id;
      logic          ordy;
      logic [DW-1:0] dv;
      logic [1:0]    ecnt;
      logic          eov;
      logic          eir;
      logic [DW-1:0] edat;
   } vec_t;

   logic          clk;
   logic          rst;
   logic          flush;
   logic [DW-1:0] def_val;
   logic [1:0]    count;

   gen_skid_pipe_if #(.DW(DW)) bus_if ();

   gen_skid_pipe #(.DW(DW)) dut (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .def_val (def_val),
      .bus     (bus_if.slave),
      .count   (count)
   );

   vec_t          tv [NV];
   logic [DW-1:0] sb [$];
   logic          prev_ir;
   int            n_pass;
   int            n_total;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      else
         n_pass++;
   endtask

   function automatic vec_t mk(
      input logic fl, input logic iv, input logic [DW-1:0] id,
      input logic ordy, input logic [DW-1:0] dv, input logic [1:0] ecnt,
      input logic eov, input logic eir, input logic [DW-1:0] edat);
      vec_t v;
      v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy; v.dv = dv;
      v.ecnt = ecnt; v.eov = eov; v.eir = eir; v.edat = edat;
      return v;
   endfunction

   task automatic apply(input int i);
      logic          ofire;
      logic [DW-1:0] odat;
      vec_t          v;
      v = tv[i];
      flush           = v.fl;
      def_val         = v.dv;
      bus_if.in_valid = v.iv;
      bus_if.in_data  = v.id;
      bus_if.out_ready = v.ordy;
      #1;
      ofire = bus_if.out_valid & bus_if.out_ready;
      odat  = bus_if.out_data;
      if (ofire) begin
         if (sb.size() == 0)
            chk($sformatf("v%0d.sb_empty", i), 32'd1, 32'd0);
         else
            chk($sformatf("v%0d.sb_data", i), odat, sb.pop_front());
      end
      if (v.fl)
         sb.delete();
      else if (v.iv && prev_ir)
         sb.push_back(v.id);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d.count", i), {30'd0, count}, {30'd0, v.ecnt});
      chk($sformatf("v%0d.out_valid", i), {31'd0, bus_if.out_valid},
          {31'd0, v.eov});
      chk($sformatf("v%0d.in_ready", i), {31'd0, bus_if.in_ready},
          {31'd0, v.eir});
      chk($sformatf("v%0d.out_data", i), bus_if.out_data, v.edat);
      prev_ir = v.eir;
   endtask

   task automatic chk_clear(input string tag, input logic [DW-1:0] dv);
      chk({tag, ".count"}, {30'd0, count}, 32'd0);
      chk({tag, ".out_valid"}, {31'd0, bus_if.out_valid}, 32'd0);
      chk({tag, ".in_ready"}, {31'd0, bus_if.in_ready}, 32'd1);
      chk({tag, ".out_data"}, bus_if.out_data, dv);
   endtask

   initial begin
      logic [DW-1:0] dbf;
      dbf = 32'hDEAD_BEEF;
      n_pass  = 0;
      n_total = 0;
      prev_ir = 1'b1;

      // streaming
      tv[0]  = mk(0, 1, 32'h1, 1, dbf, 2'd1, 1, 1, 32'h1);
      tv[1]  = mk(0, 1, 32'h2, 1, dbf, 2'd1, 1, 1, 32'h2);
      tv[2]  = mk(0, 1, 32'h3, 1, dbf, 2'd1, 1, 1, 32'h3);
      tv[3]  = mk(0, 0, 32'h0, 1, dbf, 2'd0, 0, 1, 32'h3);
      // back-pressure, then drain in order
      tv[4]  = mk(0, 1, 32'hA, 0, dbf, 2'd1, 1, 1, 32'hA);
      tv[5]  = mk(0, 1, 32'hB, 0, dbf, 2'd2, 1, 0, 32'hA);
      tv[6]  = mk(0, 1, 32'hC, 0, dbf, 2'd2, 1, 0, 32'hA);
      tv[7]  = mk(0, 0, 32'h0, 1, dbf, 2'd1, 1, 1, 32'hB);
      tv[8]  = mk(0, 0, 32'h0, 1, dbf, 2'd0, 0, 1, 32'hB);
      // flush of a full buffer with a competing push
      tv[9]  = mk(0, 1, 32'hA, 0, dbf, 2'd1, 1, 1, 32'hA);
      tv[10] = mk(0, 1, 32'hB, 0, dbf, 2'd2, 1, 0, 32'hA);
      tv[11] = mk(1, 1, 32'hC, 0, 32'h0, 2'd0, 0, 1, 32'h0);
      tv[12] = mk(0, 0, 32'h0, 1, 32'h0, 2'd0, 0, 1, 32'h0);
      // same-cycle in_fire and out_fire at count=1
      tv[13] = mk(0, 1, 32'h5, 0, 32'h0, 2'd1, 1, 1, 32'h5);
      tv[14] = mk(0, 1, 32'h6, 1, 32'h0, 2'd1, 1, 1, 32'h6);
      tv[15] = mk(0, 0, 32'h0, 1, 32'h0, 2'd0, 0, 1, 32'h6);
      // flush concurrent with out_fire
      tv[16] = mk(0, 1, 32'h8, 0, 32'h0, 2'd1, 1, 1, 32'h8);
      tv[17] = mk(1, 0, 32'h0, 1, 32'h0, 2'd0, 0, 1, 32'h0);
      // fill before mid-operation reset
      tv[18] = mk(0, 1, 32'h11, 0, 32'h0, 2'd1, 1, 1, 32'h11);
      tv[19] = mk(0, 1, 32'h12, 0, 32'h0, 2'd2, 1, 0, 32'h11);
      // after reset
      tv[20] = mk(0, 1, 32'h7, 1, 32'h0, 2'd1, 1, 1, 32'h7);
      tv[21] = mk(0, 0, 32'h0, 1, 32'h0, 2'd0, 0, 1, 32'h7);

      rst = 1'b1;
      flush = 1'b0;
      def_val = dbf;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = '0;
      bus_if.out_ready = 1'b0;
      #1 rst = 1'b0;
      #1 chk_clear("rst_async", dbf);

      // input activity during reset is ignored
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 32'h99;
      @(negedge clk);
      @(negedge clk);
      chk_clear("rst_hold", dbf);
      bus_if.in_valid = 1'b0;
      rst = 1'b1;

      for (int i = 0; i < 20; i++) apply(i);

      #2;
      bus_if.in_valid = 1'b0;
      rst = 1'b0;
      #1 chk_clear("rst_mid", 32'h0);
      sb.delete();
      prev_ir = 1'b1;
      #1 rst = 1'b1;
      @(negedge clk);
      chk_clear("rst_after", 32'h0);

      for (int i = 20; i < NV; i++) apply(i);

      chk("sb_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gen_skid_pipe.md
Name: gen_skid_pipe

Overview:
- Elastic pipeline stage with a 2-entry buffer (main register plus skid register) and valid/ready handshake on both sides.
- It is the back-pressure-aware counterpart of our hold/flush pipeline registers. The consumer side throttles the producer with out_ready, rather than the producer being frozen by an external hold.
- It sits between core pipeline stages, and between the core and bus/peripheral paths, wherever a stall must be registered and must not ripple combinationally upstream.

Parameters:
DW, 32, payload width in bits

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush; discards all buffered entries
def_val  input  DW  value loaded into out_data on reset and on flush
in_valid  input  1  upstream has data on in_data
in_ready  output  1  stage can accept data this cycle
in_data  input  DW  upstream payload
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  DW  downstream payload, driven directly from the main register
count  output  2  number of buffered entries, 0..2

Behaviour:
- Reset: rst is asynchronous and active-low. While rst=0, all state clears immediately without waiting for a clock edge:
  - main_valid=0, skid_valid=0, out_valid=0, count=0
  - out_data=def_val, skid data=def_val
- in_ready = ~skid_valid.
  - It is a pure register output with no combinational path from out_ready.
  - It reads 1 during and after reset; input activity while rst=0 is ignored.
- Define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
- out_valid = main_valid.
- count = main_valid + skid_valid.
- Normal operation (flush=0), evaluated on each rising edge:
  - Main load: if main_valid=0 or out_fire, the main register loads as follows:
    - skid data, if skid_valid=1; skid_valid then clears.
    - in_data, if in_fire=1 and skid_valid=0.
    - Otherwise main_valid goes to 0 and out_data holds its last value.
  - Skid load: if in_fire=1 and main_valid=1 and out_fire=0, the skid register captures in_data and skid_valid goes to 1.
  - If skid_valid=1 then in_ready=0, so in_fire is impossible and no third entry can arrive.
- Latency: an accepted word appears on out_data/out_valid exactly 1 cycle after in_fire when the stage is empty.
- Throughput: sustained 1 word/cycle while out_ready=1.
- Ordering: strict FIFO; the skid entry always leaves before any newer input.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change, except on flush or reset.
- Flush (flush=1 at an edge) has highest priority after reset:
  - main_valid=0, skid_valid=0, out_data=def_val.
  - Any in_fire in the same cycle is dropped.
  - Any out_fire in the same cycle still counts as consumed by downstream; no re-delivery.
- Simultaneous in_fire and out_fire with count=1: the main register is replaced by in_data and count stays 1.
- Simultaneous in_fire and out_fire with count=0: cannot occur, because out_valid=0.
- Reset asserted mid-transfer: all entries are lost immediately. No partial state survives, and buffered data is never emitted after rst rises.

Test Plan:
1. Reset with rst=0 and def_val=32'hDEAD_BEEF -> out_valid=0, out_data=32'hDEAD_BEEF, count=0, in_ready=1. Check asynchronously, before any clk edge.
2. Streaming: out_ready=1; push 0x1,0x2,0x3 on consecutive cycles -> out_data shows 0x1,0x2,0x3 one cycle after each in_fire; count stays 1; in_ready stays 1.
3. Back-pressure: out_ready=0; push 0xA then 0xB -> count=2, in_ready=0, out_data=0xA held stable. Raise out_ready -> 0xA then 0xB delivered in order; in_ready=1 one cycle after 0xA is consumed.
4. Flush with a full buffer holding 0xA,0xB, asserted together with in_valid=1 and in_data=0xC, def_val=0 -> next cycle count=0, out_valid=0, out_data=0; 0xC is never emitted.
5. Same-cycle in_fire and out_fire with count=1 (main=0x5, input 0x6, out_ready=1) -> next cycle out_data=0x6, count=1, skid_valid=0.
6. Mid-operation reset with count=2: pulse rst low for less than one cycle -> outputs clear immediately. After release, a new push of 0x7 yields out_data=0x7 with no stale entries.
